// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: fetch handshake, decode, ALU execute,
// accumulator write-back, register store and halt, with a saturating retire counter.
module control_sequencer #(
    parameter int RF_DEPTH = 4,
    parameter int CNT_W    = 16,
    localparam int AW      = $clog2(RF_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [AW+3:0]       instruction,
    input  logic                resume,
    output logic [2:0]          ALU_opcode,
    output logic                ALU_ce,
    output logic [AW-1:0]       RF_addr,
    output logic [RF_DEPTH-1:0] RF_ce,
    output logic                A_ce,
    output logic                busy,
    output logic                halted,
    output logic                illegal,
    output logic [CNT_W-1:0]    retired_cnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXEC    = 3'd2;
    localparam logic [2:0] S_WB      = 3'd3;
    localparam logic [2:0] S_STORE   = 3'd4;
    localparam logic [2:0] S_HALTED  = 3'd5;

    localparam logic [3:0] OP_NOP   = 4'b1000;
    localparam logic [3:0] OP_STORE = 4'b1001;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [AW+3:0]    r_instr;
    logic [CNT_W-1:0] r_cnt;

    logic [3:0]    w_op;
    logic [AW-1:0] w_addr;
    logic          w_is_alu;
    logic          w_is_illegal;
    logic          w_accept;
    logic          w_retire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_op         = r_instr[AW+3:AW];
    assign w_addr       = r_instr[AW-1:0];
    assign w_is_alu     = ~w_op[3];
    assign w_is_illegal = w_op[3] && (w_op != OP_NOP) && (w_op != OP_STORE) && (w_op != OP_HALT);
    assign w_accept     = (r_state == S_IDLE) && instr_valid;

    // NOP and HALT retire straight out of DECODE; HALT counts on entry to HALTED.
    assign w_retire = (r_state == S_WB) || (r_state == S_STORE) ||
                      ((r_state == S_DECODE) && ((w_op == OP_NOP) || (w_op == OP_HALT)));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (instr_valid) w_state_nxt = S_DECODE;
            S_DECODE: begin
                if (w_is_alu)               w_state_nxt = S_EXEC;
                else if (w_op == OP_STORE)  w_state_nxt = S_STORE;
                else if (w_op == OP_HALT)   w_state_nxt = S_HALTED;
                else                        w_state_nxt = S_IDLE;
            end
            S_EXEC:   w_state_nxt = S_WB;
            S_WB:     w_state_nxt = S_IDLE;
            S_STORE:  w_state_nxt = S_IDLE;
            S_HALTED: if (resume) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_instr <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) r_instr <= instruction;
            if (w_retire) r_cnt   <= sat_inc(r_cnt);
        end
    end

    // Outputs are pure decodes of registered state, so no input reaches an output.
    assign instr_ready = (r_state == S_IDLE);
    assign busy        = (r_state == S_DECODE) || (r_state == S_EXEC) ||
                         (r_state == S_WB) || (r_state == S_STORE);
    assign halted      = (r_state == S_HALTED);
    assign illegal     = (r_state == S_DECODE) && w_is_illegal;
    assign ALU_ce      = (r_state == S_EXEC);
    assign ALU_opcode  = (r_state == S_EXEC) ? w_op[2:0] : 3'b000;
    assign RF_addr     = ((r_state == S_EXEC) || (r_state == S_STORE)) ? w_addr : '0;
    assign RF_ce       = (r_state == S_STORE) ? ({{(RF_DEPTH-1){1'b0}}, 1'b1} << w_addr) : '0;
    assign A_ce        = (r_state == S_WB);
    assign retired_cnt = r_cnt;

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The parameter RF_DEPTH SHALL default to 4 and give the register-file entry count; it SHALL be a power of two and at least 2, and AW = clog2(RF_DEPTH).
REQ-002 The parameter CNT_W SHALL default to 16 and give the width of the retired-instruction counter.
REQ-003 The clock and reset SHALL be one clock and a synchronous, active-high reset, as follows.
- clk: input, 1 bit, the only clock; all state updates on its rising edge.
- rst: input, 1 bit, synchronous active-high reset.
REQ-004 The remaining ports SHALL be:
- instr_valid: input, 1 bit, instruction word present.
- instr_ready: output, 1 bit, sequencer can accept an instruction.
- instruction: input, 4+AW bits; [AW+3:AW] is the opcode, [AW-1:0] is the register address.
- resume: input, 1 bit, leave HALTED.
- ALU_opcode: output, 3 bits, ALU operation select.
- ALU_ce: output, 1 bit, ALU enable.
- RF_addr: output, AW bits, register-file address.
- RF_ce: output, RF_DEPTH bits, one-hot register write enables.
- A_ce: output, 1 bit, accumulator capture enable.
- busy: output, 1 bit, instruction in flight.
- halted: output, 1 bit, HALTED state.
- illegal: output, 1 bit, undefined opcode in DECODE.
- retired_cnt: output, CNT_W bits, completed-instruction count.

Function
REQ-005 The opcode encoding SHALL be:
- 4'b0xxx: ALU op, with ALU_opcode = opcode[2:0].
- 4'b1000: NOP.
- 4'b1001: STORE.
- 4'b1111: HALT.
- All other values: illegal.
REQ-006 The state machine SHALL have the states IDLE, DECODE, EXEC, WB, STORE_S and HALTED.
REQ-007 instr_ready SHALL be 1 only in IDLE, and an instruction SHALL be accepted on a clock edge where instr_valid=1 and instr_ready=1.
REQ-008 On acceptance, the instruction SHALL be captured into an internal register and the state SHALL become DECODE; with no acceptance, IDLE SHALL hold.
REQ-009 DECODE SHALL last one cycle and then move to:
- EXEC for an ALU op;
- STORE_S for STORE;
- IDLE for NOP;
- HALTED for HALT;
- IDLE for an illegal opcode.
REQ-010 EXEC SHALL last one cycle with ALU_ce=1, ALU_opcode equal to the captured opcode[2:0] and RF_addr equal to the captured address, then move to WB.
REQ-011 WB SHALL last one cycle with A_ce=1 (other enables 0), then move to IDLE.
REQ-012 STORE_S SHALL last one cycle with RF_ce one-hot at bit RF_addr, RF_addr equal to the captured address and A_ce=0, then move to IDLE.
REQ-013 HALTED SHALL hold, with halted=1 and instr_ready=0, until resume=1 is sampled, then move to IDLE; resume SHALL be ignored in every other state.
REQ-014 Outside their active states, ALU_ce, A_ce and RF_ce SHALL be 0, and ALU_opcode and RF_addr SHALL be 0.
REQ-015 All outputs SHALL be decoded only from the state register, the captured instruction register and the counter, with no combinational path from any input to any output.
REQ-016 busy SHALL be 1 in DECODE, EXEC, WB and STORE_S, and 0 in IDLE and HALTED.
REQ-017 illegal SHALL be 1 only in the DECODE cycle of an undefined opcode, and that instruction SHALL NOT be retired.
REQ-018 Accept-to-ready latency SHALL be:
- ALU op: 4 cycles (DECODE, EXEC, WB, IDLE);
- STORE: 3 cycles;
- NOP or illegal: 2 cycles.
REQ-019 retired_cnt SHALL increment by 1 on the edge leaving WB, leaving STORE_S, leaving DECODE for a NOP, and entering HALTED.
REQ-020 retired_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 The sequencer SHALL accept at most one instruction in flight, and instr_valid while not ready SHALL be ignored, with no capture.
REQ-022 Behaviour SHALL be identical for every legal RF_DEPTH, and RF_ce SHALL never have more than one bit set.

Reset
REQ-023 rst=1 sampled on any edge SHALL force, on that edge:
- state = IDLE;
- captured instruction = 0;
- retired_cnt = 0;
- ALU_ce = A_ce = busy = halted = illegal = 0;
- RF_ce = 0, ALU_opcode = 0, RF_addr = 0.
REQ-024 While rst=1, instr_ready SHALL be 1 (the state is IDLE), but no instruction SHALL be accepted.
REQ-025 Reset SHALL take priority over acceptance, resume and every state transition, and SHALL abort any instruction in flight with no partial enables in the following cycle.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- ALU op (RF_DEPTH=4, instruction=6'b0101_10): DECODE, then EXEC with ALU_ce=1, ALU_opcode=3'b101, RF_addr=2, then WB with A_ce=1; instr_ready returns 4 cycles after acceptance; retired_cnt=1.
- STORE to address 3 (6'b1001_11): RF_ce=4'b1000 for exactly one cycle, A_ce=0 throughout, retired_cnt increments.
- Illegal opcode 4'b1100: illegal=1 for one DECODE cycle, no enables asserted, retired_cnt unchanged, back in IDLE after 2 cycles.
- HALT, then instr_valid held at 1 for 10 cycles, then resume=1: halted=1, instr_ready=0 and no acceptance during the hold; IDLE on the cycle after resume.
- rst asserted during EXEC: next cycle all outputs are at their reset values and no WB/A_ce pulse occurs.
- CNT_W=2 with 5 NOPs: retired_cnt saturates at 3; with RF_DEPTH=8, a STORE to address 5 gives RF_ce=8'b0010_0000.
